uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte-stream UART transmitter (8N1) sitting directly downstream of the core's parallel result output, inside the tt_um_salomon9920_core top.
- Core pushes bytes through a valid/ready port; a small FIFO decouples them from the serializer.
- Serializer drives one uo_out pin as the TX line, so bench and board see the core's results serially.

Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the FIFO; power of two, 2..16.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  design enable; low blocks the start of new frames.
- wr_valid  input  1  core offers a byte.
- wr_data  input  8  byte to send; sent LSB first.
- wr_ready  output  1  FIFO can accept; equals !full, registered-state based.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when wr_valid is high while wr_ready is low; cleared only by reset.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n); all flops clear on rst_n low with no clock needed.
- Reset values: tx=1, busy=0, wr_ready=1, level=0, overflow=0, state=IDLE, baud counter=0, bit index=0, FIFO pointers=0.
- Push: occurs on any edge with wr_valid && wr_ready; level increments that edge.
- Full FIFO: wr_ready=0 even if a pop happens the same cycle; no bypass path.
- Simultaneous push and pop, FIFO not full: level unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by the level counter.
- State IDLE: tx=1.
  - If ena=1 and FIFO non-empty at edge k: pop the head into shift register, go to START, tx=0 from edge k.
  - Byte pushed into an empty FIFO at edge k: start bit begins at edge k+1.
- State START: tx=0 for exactly BAUD_DIV cycles, then DATA with bit index 0.
- State DATA: tx=shift[0] for BAUD_DIV cycles per bit; shift right after each bit; after bit 7, go to STOP.
- State STOP: tx=1 for BAUD_DIV cycles. At the end:
  - If ena=1 and FIFO non-empty, pop and go directly to START, with no idle gap.
  - Otherwise go to IDLE.
- Frame length: exactly 10*BAUD_DIV cycles; back-to-back frames are contiguous.
- Baud counter: counts 0..BAUD_DIV-1 and wraps to 0 on each bit boundary; reset to 0 on every state change out of IDLE.
- ena low mid-frame: current frame completes normally; no new frame starts until ena=1; pushes are still accepted.
- tx is driven from a flop, so it is glitch-free.
- rst_n asserted mid-frame: tx returns to 1 immediately (asynchronous); FIFO contents are discarded.
- busy = (state != IDLE) || (level != 0).

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP}, 2 bits;
  - UART_DATA_W = 8;
  - UART_STOP_BITS = 1;
  - default BAUD_DIV constant.
- One natural sub-module: sync_fifo, parameterised by width and depth, with push/pop/level/full/empty.
- Serializer FSM and baud counter stay in uart_tx_fifo.

Test Plan:
- Reset, then idle 50 cycles with BAUD_DIV=4 -> tx=1, busy=0, wr_ready=1, level=0 throughout.
- Push 0xA5 at edge k -> tx=0 over cycles k+1..k+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), tx=1 for 4 cycles, busy drops at k+41.
- Push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap; the bench UART monitor decodes 00, FF, 55 in order.
- With ena=0, push 5 bytes into FIFO_DEPTH=4:
  - wr_ready=0 after the 4th push, 5th push sets overflow=1, level=4, tx stays 1;
  - then ena=1 -> 4 frames sent, level drains to 0, overflow stays 1.
- Drop ena during DATA of a frame with 2 bytes queued -> that frame finishes (40 cycles total), then tx holds 1 and level=2 until ena returns.
- Assert rst_n low mid-DATA for 3 cycles, with no clock edge at assertion -> tx=1 immediately, level=0, overflow=0; the next push produces a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DATA_W           = 8;
  localparam int unsigned UART_STOP_BITS        = 1;
  localparam int unsigned UART_DEFAULT_BAUD_DIV = 434;
  localparam int unsigned UART_BAUD_CNT_W       = 16;
  localparam int unsigned UART_BIT_IDX_W        = 3;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO; the level counter tells full from empty, pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata_c,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_next_c,
  output logic                   empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full_c;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full_c       = (level == LW'(DEPTH));
  assign empty_c      = (level == '0);
  assign push_ok_c    = push && !full_c;
  assign pop_ok_c     = pop && !empty_c;
  assign rdata_c      = mem[rd_ptr];
  assign level_next_c = level + LW'(push_ok_c) - LW'(pop_ok_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok_c) rd_ptr <= rd_ptr + AW'(1);
      level <= level_next_c;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; back-to-back frames leave no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        wr_valid,
  input  logic [UART_DATA_W-1:0]      wr_data,
  output logic                        wr_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e                state_q, state_d;
  logic [UART_BAUD_CNT_W-1:0] cnt_q, cnt_d;
  logic [UART_BIT_IDX_W-1:0]  bit_q, bit_d;
  logic [UART_DATA_W-1:0]     shift_q, shift_d;
  logic                       tx_d;
  logic                       pop_c;
  logic                       push_c;
  logic                       bit_end_c;
  logic [UART_DATA_W-1:0]     fifo_rdata_c;
  logic [LW-1:0]              fifo_level_next_c;
  logic                       fifo_empty_c;

  assign push_c    = wr_valid && wr_ready;
  assign bit_end_c = (cnt_q == UART_BAUD_CNT_W'(BAUD_DIV - 1));

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push_c),
    .wdata        (wr_data),
    .pop          (pop_c),
    .rdata_c      (fifo_rdata_c),
    .level        (level),
    .level_next_c (fifo_level_next_c),
    .empty_c      (fifo_empty_c)
  );

  // Serializer: tx_d is the line value for the cycle after the edge, so tx stays a pure flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end_c ? '0 : cnt_q + UART_BAUD_CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (ena && !fifo_empty_c) begin
          pop_c   = 1'b1;
          shift_d = fifo_rdata_c;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_q == UART_BIT_IDX_W'(UART_DATA_W - 1)) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + UART_BIT_IDX_W'(1);
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (bit_q == UART_BIT_IDX_W'(UART_STOP_BITS - 1)) begin
            bit_d = '0;
            if (ena && !fifo_empty_c) begin
              pop_c   = 1'b1;
              shift_d = fifo_rdata_c;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + UART_BIT_IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      wr_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
      busy     <= (state_d != IDLE) || (fifo_level_next_c != '0);
      wr_ready <= (fifo_level_next_c != LW'(FIFO_DEPTH));
      overflow <= overflow || (wr_valid && !wr_ready);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model, UART decoder, directed and random traffic.
module tb_uart_tx_fifo;

  localparam int B     = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  uart_tx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queue plus a countdown over the current 10-bit frame.
  logic [7:0] mq[$];
  logic [7:0] mon_exp[$];
  int         m_left = 0;
  logic [9:0] m_frame = '1;
  logic       m_ovf = 1'b0;
  bit         m_rdy;
  logic [7:0] m_head;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mon_exp.delete();
      m_left  = 0;
      m_frame = '1;
      m_ovf   = 1'b0;
    end else begin
      m_rdy = (mq.size() != DEPTH);
      if (m_left > 1) m_left--;
      else if (ena && mq.size() > 0) begin
        m_head  = mq.pop_front();
        m_frame = {1'b1, m_head, 1'b0};
        m_left  = 10 * B;
      end else m_left = 0;
      if (wr_valid && m_rdy) begin
        mq.push_back(wr_data);
        mon_exp.push_back(wr_data);
      end
      if (wr_valid && !m_rdy) m_ovf = 1'b1;
    end
  end

  function automatic logic model_tx();
    if (m_left > 0) return m_frame[(10 * B - m_left) / B];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("tx", 32'(tx), 32'(model_tx()));
      check("level", 32'(level), 32'(mq.size()));
      check("busy", 32'(busy), 32'((m_left > 0) || (mq.size() > 0)));
      check("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // UART decoder: samples mid-bit and compares each byte with the push order.
  bit         mon_on = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  logic [7:0] mon_want;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_on  = 0;
      mon_cnt = 0;
    end else if (chk_on) begin
      if (!mon_on) begin
        if (tx === 1'b0) begin
          mon_on  = 1;
          mon_cnt = 0;
        end
      end else mon_cnt++;
      if (mon_on && (mon_cnt % B == B / 2)) begin
        if (mon_cnt / B >= 1 && mon_cnt / B <= 8) mon_byte[mon_cnt / B - 1] = tx;
        if (mon_cnt / B == 0) check("start_bit", 32'(tx), 32'(0));
        if (mon_cnt / B == 9) begin
          check("stop_bit", 32'(tx), 32'(1));
          check("uart_expected", 32'(mon_exp.size() != 0), 32'(1));
          if (mon_exp.size() != 0) begin
            mon_want = mon_exp.pop_front();
            check("uart_byte", 32'(mon_byte), 32'(mon_want));
          end
          mon_on = 0;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) @(negedge clk);
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  logic [9:0] a5_frame;
  int         blen;

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_wr_ready", 32'(wr_ready), 32'(1));
    check("rst_level", 32'(level), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    rst_n  = 1'b1;
    chk_on = 1;
    repeat (50) @(negedge clk);

    // Single 0xA5 frame, timed against a constant bit pattern.
    a5_frame = {1'b1, 8'hA5, 1'b0};
    push_byte(8'hA5);
    for (int j = 1; j <= 41; j++) begin
      @(negedge clk);
      if (j <= 40) check("a5_tx", 32'(tx), 32'(a5_frame[(j - 1) / B]));
      if (j == 40) check("a5_busy_end", 32'(busy), 32'(1));
      if (j == 41) check("a5_busy_drop", 32'(busy), 32'(0));
    end

    // Three bytes on consecutive cycles give three contiguous frames.
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    @(negedge clk);
    wr_data = 8'hFF;
    @(negedge clk);
    wr_data = 8'h55;
    @(negedge clk);
    wr_valid = 1'b0;
    blen = 0;
    for (int i = 0; i < 500 && busy; i++) begin
      blen++;
      @(negedge clk);
    end
    check("b2b_busy_len", 32'(blen), 32'(3 * 10 * B - 1));
    repeat (5) @(negedge clk);

    // Fill with ena low, overflow on the fifth push, then drain.
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h11 * (i + 1));
      @(negedge clk);
      check("fill_level", 32'(level), 32'((i < DEPTH) ? i + 1 : DEPTH));
    end
    wr_valid = 1'b0;
    check("full_wr_ready", 32'(wr_ready), 32'(0));
    check("full_overflow", 32'(overflow), 32'(1));
    check("full_tx", 32'(tx), 32'(1));
    ena = 1'b1;
    wait_idle(400);
    check("drain_level", 32'(level), 32'(0));
    check("drain_overflow", 32'(overflow), 32'(1));

    // ena dropped mid-frame: frame completes, queue holds.
    wr_valid = 1'b1;
    wr_data  = 8'hA1;
    @(negedge clk);
    wr_data = 8'hB2;
    @(negedge clk);
    wr_data = 8'hC3;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (10) @(negedge clk);
    ena = 1'b0;
    repeat (60) @(negedge clk);
    check("hold_level", 32'(level), 32'(2));
    check("hold_tx", 32'(tx), 32'(1));
    ena = 1'b1;
    wait_idle(300);

    // Asynchronous reset in the middle of a data bit.
    push_byte(8'h3C);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'(1));
    check("arst_level", 32'(level), 32'(0));
    check("arst_overflow", 32'(overflow), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_byte(8'h96);
    wait_idle(100);

    // Random traffic with occasional ena toggling.
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom % 4 == 0);
      wr_data  = 8'($urandom);
      if ($urandom % 150 == 0) ena = ~ena;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    ena      = 1'b1;
    wait_idle(1000);
    repeat (20) @(negedge clk);
    check("uart_all_decoded", 32'(mon_exp.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
